// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search slice: FSM state encodings,
// plaintext alphabet bounds and the S-RAM port owner encoding.
package rc4_pkg;

  localparam int unsigned STATE_W = 4;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_INC_I     = 4'd1;
  localparam state_t ST_RD_I_WAIT = 4'd2;
  localparam state_t ST_RD_I      = 4'd3;
  localparam state_t ST_CALC_J    = 4'd4;
  localparam state_t ST_SET_J     = 4'd5;
  localparam state_t ST_RD_J_WAIT = 4'd6;
  localparam state_t ST_RD_J      = 4'd7;
  localparam state_t ST_WR_I      = 4'd8;
  localparam state_t ST_WR_J      = 4'd9;
  localparam state_t ST_SET_F     = 4'd10;
  localparam state_t ST_RD_F_WAIT = 4'd11;
  localparam state_t ST_RD_F      = 4'd12;
  localparam state_t ST_WR_OUT    = 4'd13;
  localparam state_t ST_CHECK     = 4'd14;
  localparam state_t ST_DONE      = 4'd15;

  // Accepted plaintext: space or lowercase a..z
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;

  // Value of mem_owner selecting who drives the S-RAM port
  localparam logic OWNER_SHUFFLE = 1'b0;
  localparam logic OWNER_DECRYPT = 1'b1;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational alphabet test: high when the byte is a space or a..z.
import rc4_pkg::*;

module rc4_char_check (
  input  logic [7:0] byte_in,
  output logic       valid
);

  // Range compare against the shared alphabet bounds
  always_comb begin
    valid = (byte_in == CHAR_SPACE) ||
            ((byte_in >= CHAR_LO) && (byte_in <= CHAR_HI));
  end

endmodule

// File: rtl/rc4_decrypt.sv
// RC4 keystream generator and decryptor. Walks the already-shuffled S array,
// XORs each keystream byte with the encrypted ROM and writes the plaintext to
// the decrypted RAM, optionally aborting on the first non-text byte.
import rc4_pkg::*;

module rc4_decrypt #(
  parameter int MSG_LEN  = 32,
  parameter int VALIDATE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       done,
  output logic       key_valid,
  output logic       mem_owner,
  output logic [7:0] s_addr,
  output logic [7:0] s_data,
  output logic       s_wen,
  input  logic [7:0] s_q,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_q,
  output logic [7:0] dec_addr,
  output logic [7:0] dec_data,
  output logic       dec_wen
);

  localparam logic [8:0] K_LAST = 9'(MSG_LEN - 1);

  state_t     state;
  logic [7:0] i;
  logic [7:0] j;
  logic [8:0] k;
  logic [7:0] si;
  logic [7:0] sj;
  logic [7:0] f;
  logic [7:0] enc;
  logic       char_ok;

  // dec_data still holds the byte written in WR_OUT while in CHECK
  rc4_char_check u_char_check (
    .byte_in (dec_data),
    .valid   (char_ok)
  );

  // Main PRGA sequencer; every output is a register updated here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      si        <= '0;
      sj        <= '0;
      f         <= '0;
      enc       <= '0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      mem_owner <= OWNER_SHUFFLE;
      s_addr    <= '0;
      s_data    <= '0;
      s_wen     <= 1'b0;
      rom_addr  <= '0;
      dec_addr  <= '0;
      dec_data  <= '0;
      dec_wen   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            i         <= '0;
            j         <= '0;
            k         <= '0;
            mem_owner <= OWNER_DECRYPT;
            state     <= ST_INC_I;
          end
        end
        ST_INC_I: begin
          i      <= i + 8'd1;
          s_addr <= i + 8'd1;
          state  <= ST_RD_I_WAIT;
        end
        ST_RD_I_WAIT: state <= ST_RD_I;
        ST_RD_I: begin
          si    <= s_q;
          state <= ST_CALC_J;
        end
        ST_CALC_J: begin
          j     <= j + si;
          state <= ST_SET_J;
        end
        ST_SET_J: begin
          s_addr <= j;
          state  <= ST_RD_J_WAIT;
        end
        ST_RD_J_WAIT: state <= ST_RD_J;
        ST_RD_J: begin
          sj    <= s_q;
          state <= ST_WR_I;
        end
        // S[i] is written before S[j], so i==j leaves the original si in place
        ST_WR_I: begin
          s_addr <= i;
          s_data <= sj;
          s_wen  <= 1'b1;
          state  <= ST_WR_J;
        end
        ST_WR_J: begin
          s_addr <= j;
          s_data <= si;
          s_wen  <= 1'b1;
          state  <= ST_SET_F;
        end
        ST_SET_F: begin
          s_wen    <= 1'b0;
          s_addr   <= si + sj;
          rom_addr <= k[7:0];
          state    <= ST_RD_F_WAIT;
        end
        ST_RD_F_WAIT: state <= ST_RD_F;
        ST_RD_F: begin
          f     <= s_q;
          enc   <= rom_q;
          state <= ST_WR_OUT;
        end
        ST_WR_OUT: begin
          dec_addr <= k[7:0];
          dec_data <= f ^ enc;
          dec_wen  <= 1'b1;
          state    <= ST_CHECK;
        end
        ST_CHECK: begin
          dec_wen <= 1'b0;
          if ((VALIDATE == 1) && !char_ok) begin
            key_valid <= 1'b0;
            done      <= 1'b1;
            mem_owner <= OWNER_SHUFFLE;
            state     <= ST_DONE;
          end else if (k == K_LAST) begin
            key_valid <= 1'b1;
            done      <= 1'b1;
            mem_owner <= OWNER_SHUFFLE;
            state     <= ST_DONE;
          end else begin
            k     <= k + 9'd1;
            state <= ST_INC_I;
          end
        end
        ST_DONE: begin
          if (!start) begin
            done      <= 1'b0;
            key_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_decrypt.sv
// Bench for rc4_decrypt: two instances (alphabet check on / off) share the
// stimulus; a monitor compares every decrypted-RAM write and every done
// rising edge against expectations queued when each run is issued.
`timescale 1ns/1ps

module tb_rc4_decrypt;

  localparam int MSG_LEN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  logic [1:0]      done, key_valid, mem_owner, s_wen, dec_wen;
  logic [1:0][7:0] s_addr, s_data, s_q, rom_addr, rom_q, dec_addr, dec_data;

  logic [7:0] s_mem [2][256];
  logic [7:0] rom [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;

  logic [7:0] model_s [256];
  logic [7:0] model_ks [MSG_LEN];

  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct { int inst; logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int inst; logic kv; int unsigned cycles; } done_t;
  wr_t   wr_q [$];
  done_t done_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0 validates plaintext, instance 1 does not
  for (genvar g = 0; g < 2; g++) begin : g_dut
    rc4_decrypt #(.MSG_LEN(MSG_LEN), .VALIDATE((g == 0) ? 1 : 0)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .done      (done[g]),
      .key_valid (key_valid[g]),
      .mem_owner (mem_owner[g]),
      .s_addr    (s_addr[g]),
      .s_data    (s_data[g]),
      .s_wen     (s_wen[g]),
      .s_q       (s_q[g]),
      .rom_addr  (rom_addr[g]),
      .rom_q     (rom_q[g]),
      .dec_addr  (dec_addr[g]),
      .dec_data  (dec_data[g]),
      .dec_wen   (dec_wen[g])
    );
  end

  // Synchronous S RAM and ROM models with one-cycle read latency
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ld_en) s_mem[g][ld_addr] <= ld_data;
      else if (s_wen[g]) s_mem[g][s_addr[g]] <= s_data[g];
      s_q[g]   <= s_mem[g][s_addr[g]];
      rom_q[g] <= rom[rom_addr[g]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] s_init(input int mode, input int x);
    if (mode == 0) return 8'(x);
    return 8'(7 * x + 8'hF8);
  endfunction

  task automatic load_s(input int mode);
    for (int x = 0; x < 256; x++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 8'(x); ld_data = s_init(mode, x);
      model_s[x] = s_init(mode, x);
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Reference RC4 PRGA over model_s
  task automatic model_prga();
    logic [7:0] mi, mj, msi, msj;
    mi = 0; mj = 0;
    for (int n = 0; n < MSG_LEN; n++) begin
      mi = mi + 8'd1;
      msi = model_s[mi];
      mj = mj + msi;
      msj = model_s[mj];
      model_s[mi] = msj;
      model_s[mj] = msi;
      model_ks[n] = model_s[8'(msi + msj)];
    end
  endtask

  task automatic exp_wr(input int inst, input logic [7:0] a, input logic [7:0] d);
    wr_t w;
    w.inst = inst; w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic exp_done(input int inst, input logic kv, input int unsigned cycles);
    done_t e;
    e.inst = inst; e.kv = kv; e.cycles = cycles;
    done_q.push_back(e);
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (done !== 2'b11 && budget < 200);
    if (done !== 2'b11) begin
      n_cmp++; n_err++;
      $display("FAIL wait_done: timeout, done=%b required 11", done);
    end
  endtask

  task automatic begin_run();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
  endtask

  task automatic end_run();
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_flags[%0d]", tag, g),
            {27'd0, done[g], key_valid[g], mem_owner[g], s_wen[g], dec_wen[g]}, 32'd0);
      check($sformatf("%s_buses[%0d]", tag, g),
            {s_addr[g], s_data[g], rom_addr[g], dec_addr[g] | dec_data[g]}, 32'd0);
    end
  endtask

  task automatic push_basic();
    for (int g = 0; g < 2; g++) begin
      exp_wr(g, 8'd0, 8'h61);
      exp_wr(g, 8'd1, 8'h20);
      exp_done(g, 1'b1, 28);
    end
  endtask

  initial begin
    logic [1:0] prev_done;
    int idx;
    int diffs;
    int budget;
    wr_t w;
    done_t e;

    for (int x = 0; x < 256; x++) rom[x] = 8'h00;

    // Scoreboard monitor: runs alongside the stimulus below
    fork
      begin
        prev_done = '0;
        forever begin
          @(negedge clk);
          for (int g = 0; g < 2; g++) begin
            if (dec_wen[g] === 1'b1) begin
              idx = -1;
              for (int q = 0; q < wr_q.size(); q++)
                if (idx < 0 && wr_q[q].inst == g) idx = q;
              if (idx < 0) begin
                n_cmp++; n_err++;
                $display("FAIL dec_write[%0d]: unexpected write addr 0x%0h data 0x%0h, none required",
                         g, dec_addr[g], dec_data[g]);
              end else begin
                w = wr_q[idx];
                wr_q.delete(idx);
                check($sformatf("dec_addr[%0d]", g), {24'd0, dec_addr[g]}, {24'd0, w.addr});
                check($sformatf("dec_data[%0d]", g), {24'd0, dec_data[g]}, {24'd0, w.data});
              end
            end
            if (done[g] === 1'b1 && prev_done[g] === 1'b0) begin
              idx = -1;
              for (int q = 0; q < done_q.size(); q++)
                if (idx < 0 && done_q[q].inst == g) idx = q;
              if (idx < 0) begin
                n_cmp++; n_err++;
                $display("FAIL done[%0d]: unexpected done rise, none required", g);
              end else begin
                e = done_q[idx];
                done_q.delete(idx);
                check($sformatf("key_valid[%0d]", g), {31'd0, key_valid[g]}, {31'd0, e.kv});
                check($sformatf("done_latency[%0d]", g), cyc - start_cyc, e.cycles);
                check($sformatf("owner_at_done[%0d]", g), {31'd0, mem_owner[g]}, 32'd0);
              end
            end
          end
          prev_done = done;
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Identity S, plaintext "a "
    load_s(0);
    rom[0] = 8'h63; rom[1] = 8'h25;
    push_basic();
    begin_run();
    @(negedge clk);
    check("owner_after_start", {30'd0, mem_owner}, 32'd3);
    wait_done();
    for (int g = 0; g < 2; g++) begin
      check($sformatf("s2_final[%0d]", g), {24'd0, s_mem[g][2]}, 32'd3);
      check($sformatf("s3_final[%0d]", g), {24'd0, s_mem[g][3]}, 32'd2);
    end
    end_run();

    // First byte 0x43 is outside the alphabet: instance 0 aborts
    load_s(0);
    rom[0] = 8'h41; rom[1] = 8'h25;
    exp_wr(0, 8'd0, 8'h43);
    exp_done(0, 1'b0, 14);
    exp_wr(1, 8'd0, 8'h43);
    exp_wr(1, 8'd1, 8'h20);
    exp_done(1, 1'b1, 28);
    begin_run();
    wait_done();
    end_run();

    // j wraps to 0xFF on byte 0; keystream from the reference model
    load_s(1);
    model_prga();
    rom[0] = 8'h6F ^ model_ks[0];
    rom[1] = 8'h6B ^ model_ks[1];
    for (int g = 0; g < 2; g++) begin
      exp_wr(g, 8'd0, 8'h6F);
      exp_wr(g, 8'd1, 8'h6B);
      exp_done(g, 1'b1, 28);
    end
    begin_run();
    wait_done();
    for (int g = 0; g < 2; g++) begin
      diffs = 0;
      for (int x = 0; x < 256; x++) if (s_mem[g][x] !== model_s[x]) diffs++;
      check($sformatf("wrap_s_array_diffs[%0d]", g), diffs, 0);
    end
    end_run();

    // Reset while the S-RAM write enable is high
    load_s(0);
    rom[0] = 8'h63; rom[1] = 8'h25;
    begin_run();
    budget = 0;
    while (s_wen[0] !== 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    check("swen_seen_before_reset", {31'd0, s_wen[0]}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_write_swen", {30'd0, s_wen}, 32'd0);
    check("rst_mid_write_owner", {30'd0, mem_owner}, 32'd0);
    check("rst_mid_write_done", {30'd0, done}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    load_s(0);
    push_basic();
    begin_run();
    wait_done();

    // start held high through DONE must not retrigger
    repeat (30) @(negedge clk);
    check("held_done", {30'd0, done}, 32'd3);
    check("held_owner", {30'd0, mem_owner}, 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("done_clear", {30'd0, done}, 32'd0);
    load_s(0);
    push_basic();
    begin_run();
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    check("wr_queue_drained", wr_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
